free_list: RTL

FREE_LIST -- requirements
Module: free_list

---
 rtl/rv32i_types.sv | 14 +
 rtl/free_list.sv | 95 +++++++++
 2 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : rv32i_types                                                       |
// | Shared register-file sizing constants for the rename/retire datapath.      |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package rv32i_types;

    localparam int PHYS_REG_IDX = 5;
    localparam int NUM_ARCH_REG = 32;
    localparam int NUM_PHYS_REG = 64;

endpackage
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : free_list                                                         |
// | Circular free list of physical registers. A flush restores every slot as   |
// | free. Optional macro FREE_LIST_BYPASS_EN forwards enqueue to dequeue when   |
// | the list is empty.                                                          |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module free_list #(
    parameter int NUM_PHYS_REG       = rv32i_types::NUM_PHYS_REG,
    parameter int NUM_ARCH_REG       = rv32i_types::NUM_ARCH_REG,
    parameter int P_REG_IDX_NUM_BITS = rv32i_types::PHYS_REG_IDX
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                enqueue,
    input  logic [P_REG_IDX_NUM_BITS:0]                         enqueue_preg,
    input  logic                                                dequeue,
    output logic [P_REG_IDX_NUM_BITS:0]                         dequeue_preg,
    output logic                                                empty,
    output logic                                                full,
    output logic [$clog2(NUM_PHYS_REG-NUM_ARCH_REG):0]          count,
    input  logic                                                flush,
    output logic                                                overflow_err
);

    localparam int DEPTH = NUM_PHYS_REG - NUM_ARCH_REG;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = P_REG_IDX_NUM_BITS + 1;

    logic [PW-1:0] mem_q [DEPTH];
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic          overflow_err_q;
    logic          w_bypass;
    logic          w_do_enq;
    logic          w_do_deq;

    assign empty = (rd_ptr_q == wr_ptr_q);
    assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign overflow_err = overflow_err_q;

`ifdef FREE_LIST_BYPASS_EN
    assign w_bypass = empty && enqueue && dequeue && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_do_enq = enqueue && !full && !w_bypass;
    assign w_do_deq = dequeue && !empty && !flush && !w_bypass;

    assign dequeue_preg = w_bypass ? enqueue_preg : mem_q[rd_ptr_q[AW-1:0]];

    // Flush re-opens every slot: the oldest free entry sits just past the
    // post-enqueue write pointer, one full lap behind it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (flush) begin
            rd_ptr_d = {~wr_ptr_d[AW], wr_ptr_d[AW-1:0]};
        end else if (w_do_deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= {1'b1, {AW{1'b0}}};
            overflow_err_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (enqueue && full) begin
                overflow_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PW'(NUM_ARCH_REG + i);
            end
        end else if (w_do_enq) begin
            mem_q[wr_ptr_q[AW-1:0]] <= enqueue_preg;
        end
    end

endmodule
`default_nettype wire
